// File: rtl/uart_frame_ctrl_p.sv
// uart_frame_ctrl_p: host frame parser and result framer for the mat-vec engine.
// Rx frames FE,L,CMD,payload set N, load vector/matrix FIFOs or start compute;
// CMD 02 returns FE,N+1,data x N,EF built from the result FIFO.
// Optional feature macro: FRAME_TIMEOUT_EN (inter-byte timeout in Rx states).
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   rx_valid, rx_data      byte strobe and byte from UART Rx
//   tx_ready, tx_send,     UART Tx idle flag, send request,
//   tx_data                byte to transmit (held through send and wait)
//   res_data, res_empty,   result FIFO head, empty flag,
//   res_pop                one-cycle pop
//   wr_data, vec_push,     payload byte, vector FIFO push,
//   mat_push               one-hot row FIFO push (row % CH)
//   n_out, start, err,     N register, compute start pulse, error pulse,
//   busy                   controller not idle
module uart_frame_ctrl_p #(
   parameter int DATA_W      = 8,
   parameter int MAX_N       = 8,
   parameter int CH          = 4,
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       rx_valid,
   input  logic [7:0]                 rx_data,
   input  logic                       tx_ready,
   output logic                       tx_send,
   output logic [7:0]                 tx_data,
   input  logic [DATA_W-1:0]          res_data,
   input  logic                       res_empty,
   output logic                       res_pop,
   output logic [7:0]                 wr_data,
   output logic                       vec_push,
   output logic [CH-1:0]              mat_push,
   output logic [$clog2(MAX_N+1)-1:0] n_out,
   output logic                       start,
   output logic                       err,
   output logic                       busy
);

   localparam int NW = $clog2(MAX_N + 1);

   localparam logic [7:0] FE = 8'hFE;
   localparam logic [7:0] EF = 8'hEF;

   typedef enum logic [3:0] {
      S_IDLE,
      S_LEN,
      S_CMD,
      S_SET_N,
      S_LOAD_VEC,
      S_LOAD_MAT,
      S_TX_FE,
      S_TX_L,
      S_TX_DATA,
      S_TX_EF
   } state_t;

   state_t state, state_nxt;

   logic [NW-1:0] n_q;
   logic [7:0]    len_q;
   logic [NW-1:0] cnt_q;
   logic [NW-1:0] row_q;
   logic [NW-1:0] col_q;
   // Tx byte phase: 0 = send, 1 = wait for tx_ready to return
   logic          ph_q;

   logic       in_rx;
   logic       in_tx;
   logic       stall;
   logic       to_wait;
   logic       done_b;
   logic       last_cnt;
   logic       col_last;
   logic       row_last;
   logic       n_ok;
   logic       tmo;
   logic [7:0] n_p1;

   assign in_rx = (state == S_LEN) || (state == S_CMD) ||
                  (state == S_SET_N) || (state == S_LOAD_VEC) ||
                  (state == S_LOAD_MAT);
   assign in_tx = (state == S_TX_FE) || (state == S_TX_L) ||
                  (state == S_TX_DATA) || (state == S_TX_EF);

   // data bytes wait in the send phase until a result is available
   assign stall   = (state == S_TX_DATA) && res_empty && !ph_q;
   assign to_wait = in_tx && !ph_q && !stall && !tx_ready;
   assign done_b  = in_tx && ph_q && tx_ready;

   assign last_cnt = (cnt_q == n_q - NW'(1));
   assign col_last = (col_q == n_q - NW'(1));
   assign row_last = (row_q == n_q - NW'(1));
   assign n_p1     = 8'(n_q) + 8'd1;
   assign n_ok     = (int'(rx_data) >= 1) && (int'(rx_data) <= MAX_N);

`ifdef FRAME_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   logic [TW-1:0] idle_q;

   always_ff @(posedge clk) begin
      if (reset || rx_valid || !in_rx) begin
         idle_q <= '0;
      end else if (!tmo) begin
         idle_q <= idle_q + TW'(1);
      end
   end

   assign tmo = in_rx && !rx_valid && (idle_q == TW'(TIMEOUT_CYC));
`else
   assign tmo = 1'b0;
`endif

   // state and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         n_q   <= NW'(1);
         len_q <= 8'd0;
         cnt_q <= '0;
         row_q <= '0;
         col_q <= '0;
         ph_q  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == S_LEN && rx_valid) begin
            len_q <= rx_data;
         end
         if (state == S_SET_N && rx_valid && n_ok) begin
            n_q <= NW'(rx_data);
         end
         if (state == S_CMD && rx_valid &&
             (rx_data == 8'h02 || rx_data == 8'h04)) begin
            cnt_q <= '0;
            row_q <= '0;
            col_q <= '0;
         end
         if (state == S_LOAD_VEC && rx_valid) begin
            cnt_q <= cnt_q + NW'(1);
         end
         if (state == S_LOAD_MAT && rx_valid) begin
            if (col_last) begin
               col_q <= '0;
               row_q <= row_q + NW'(1);
            end else begin
               col_q <= col_q + NW'(1);
            end
         end
         if (state == S_TX_DATA && done_b) begin
            cnt_q <= cnt_q + NW'(1);
         end
         if (to_wait) begin
            ph_q <= 1'b1;
         end else if (done_b) begin
            ph_q <= 1'b0;
         end
      end
   end

   // next state
   always_comb begin
      state_nxt = state;
      if (tmo) begin
         state_nxt = S_IDLE;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (rx_valid && rx_data == FE) state_nxt = S_LEN;
            end
            S_LEN: begin
               if (rx_valid) state_nxt = S_CMD;
            end
            S_CMD: begin
               if (rx_valid) begin
                  case (rx_data)
                     8'h01:   state_nxt = S_SET_N;
                     8'h02:   state_nxt = S_TX_FE;
                     8'h04:   state_nxt = (len_q == n_p1) ? S_LOAD_VEC
                                                          : S_LOAD_MAT;
                     default: state_nxt = S_IDLE;
                  endcase
               end
            end
            S_SET_N: begin
               if (rx_valid) state_nxt = S_IDLE;
            end
            S_LOAD_VEC: begin
               if (rx_valid && last_cnt) state_nxt = S_IDLE;
            end
            S_LOAD_MAT: begin
               if (rx_valid && col_last && row_last) state_nxt = S_IDLE;
            end
            S_TX_FE: begin
               if (done_b) state_nxt = S_TX_L;
            end
            S_TX_L: begin
               if (done_b) state_nxt = S_TX_DATA;
            end
            S_TX_DATA: begin
               if (done_b && last_cnt) state_nxt = S_TX_EF;
            end
            S_TX_EF: begin
               if (done_b) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   // outputs; pulses are suppressed while reset is held
   always_comb begin
      tx_send  = 1'b0;
      tx_data  = 8'd0;
      res_pop  = 1'b0;
      vec_push = 1'b0;
      mat_push = '0;
      start    = 1'b0;
      err      = 1'b0;
      wr_data  = rx_data;
      n_out    = n_q;
      busy     = (state != S_IDLE);
      if (!reset) begin
         tx_send = in_tx && !ph_q && !stall && tx_ready;
         unique case (1'b1)
            (state == S_TX_FE):   tx_data = FE;
            (state == S_TX_L):    tx_data = n_p1;
            (state == S_TX_DATA): tx_data = 8'(res_data);
            (state == S_TX_EF):   tx_data = EF;
            default:              tx_data = 8'd0;
         endcase
         res_pop  = (state == S_TX_DATA) && done_b;
         vec_push = (state == S_LOAD_VEC) && rx_valid;
         if (state == S_LOAD_MAT && rx_valid) begin
            for (int i = 0; i < CH; i++) begin
               if (i == int'(row_q) % CH) mat_push[i] = 1'b1;
            end
         end
         start = (state == S_CMD) && rx_valid && (rx_data == 8'h03);
         err   = ((state == S_CMD) && rx_valid &&
                  ((rx_data == 8'h00) || (rx_data > 8'h04))) ||
                 ((state == S_SET_N) && rx_valid && !n_ok) ||
                 tmo;
      end
   end

endmodule

// File: tb/tb_uart_frame_ctrl_p.sv
// tb_uart_frame_ctrl_p: directed scenarios for uart_frame_ctrl_p.
// Drives Rx bytes, models UART Tx and the result FIFO, checks outputs.
module tb_uart_frame_ctrl_p;

   localparam int DATA_W = 8;
   localparam int MAX_N  = 8;
   localparam int CH     = 4;
   localparam int NW     = $clog2(MAX_N + 1);

   logic              clk = 1'b0;
   logic              reset;
   logic              rx_valid;
   logic [7:0]        rx_data;
   logic              tx_ready;
   logic              tx_send;
   logic [7:0]        tx_data;
   logic [DATA_W-1:0] res_data;
   logic              res_empty;
   logic              res_pop;
   logic [7:0]        wr_data;
   logic              vec_push;
   logic [CH-1:0]     mat_push;
   logic [NW-1:0]     n_out;
   logic              start;
   logic              err;
   logic              busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   uart_frame_ctrl_p #(
      .DATA_W(DATA_W),
      .MAX_N(MAX_N),
      .CH(CH),
      .TIMEOUT_CYC(100000)
   ) dut (
      .clk(clk),
      .reset(reset),
      .rx_valid(rx_valid),
      .rx_data(rx_data),
      .tx_ready(tx_ready),
      .tx_send(tx_send),
      .tx_data(tx_data),
      .res_data(res_data),
      .res_empty(res_empty),
      .res_pop(res_pop),
      .wr_data(wr_data),
      .vec_push(vec_push),
      .mat_push(mat_push),
      .n_out(n_out),
      .start(start),
      .err(err),
      .busy(busy)
   );

   // all tasks start and end at posedge + 1
   task automatic rx_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
   endtask

   task automatic set_n(input logic [7:0] v);
      rx_byte(8'hFE);
      rx_byte(8'h02);
      rx_byte(8'h01);
      rx_byte(v);
   endtask

   task automatic test_reset();
      logic [15:0] outs;
      reset     = 1'b1;
      rx_valid  = 1'b0;
      rx_data   = 8'h00;
      tx_ready  = 1'b1;
      res_empty = 1'b1;
      res_data  = '0;
      repeat (2) @(posedge clk);
      #5;
      outs = {tx_send, res_pop, vec_push, mat_push, start, err, busy, tx_data};
      checks++;
      if (outs !== 16'h0000) begin
         errors++;
         $display("FAIL reset_outs: got %h want 0000", outs);
      end
      checks++;
      if (n_out !== NW'(1)) begin
         errors++;
         $display("FAIL reset_n: got %0d want 1", n_out);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_busy: got %b want 0", busy);
      end
   endtask

   task automatic test_set_n();
      rx_byte(8'h55);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_ignore: busy got %b want 0", busy);
      end
      rx_byte(8'hFE);
      rx_byte(8'h02);
      rx_byte(8'h01);
      rx_data  = 8'h03;
      rx_valid = 1'b1;
      #4;
      checks++;
      if ({err, start} !== 2'b00) begin
         errors++;
         $display("FAIL set_n_pulse: err,start got %b want 00", {err, start});
      end
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      checks++;
      if (n_out !== NW'(3) || busy !== 1'b0) begin
         errors++;
         $display("FAIL set_n: n %0d busy %b want n 3 busy 0", n_out, busy);
      end
   endtask

   task automatic test_load_vec();
      logic [7:0] v [3] = '{8'hA1, 8'hB2, 8'hC3};
      rx_byte(8'hFE);
      rx_byte(8'h04);
      rx_byte(8'h04);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (busy !== 1'b1) begin
            errors++;
            $display("FAIL vec_busy%0d: got %b want 1", i, busy);
         end
         rx_data  = v[i];
         rx_valid = 1'b1;
         #4;
         checks++;
         if (vec_push !== 1'b1 || wr_data !== v[i] || mat_push !== '0) begin
            errors++;
            $display("FAIL vec_push%0d: push %b data %h mat %b want 1 %h 0000",
                     i, vec_push, wr_data, mat_push, v[i]);
         end
         @(posedge clk);
         #1;
         rx_valid = 1'b0;
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL vec_end: busy got %b want 0", busy);
      end
   endtask

   task automatic test_set_n_range();
      // {is_cmd, byte, exp_err, exp_n}
      logic       is_cmd [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [7:0] b      [5] = '{8'h09, 8'h00, 8'h08, 8'h07, 8'h09};
      logic       e_err  [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      int         e_n    [5] = '{3, 3, 8, 8, 8};
      for (int i = 0; i < 5; i++) begin
         rx_byte(8'hFE);
         if (is_cmd[i]) begin
            rx_byte(8'h01);
         end else begin
            rx_byte(8'h02);
            rx_byte(8'h01);
         end
         rx_data  = b[i];
         rx_valid = 1'b1;
         #4;
         checks++;
         if (err !== e_err[i] || start !== 1'b0) begin
            errors++;
            $display("FAIL range%0d_err: err %b start %b want %b 0",
                     i, err, start, e_err[i]);
         end
         @(posedge clk);
         #1;
         rx_valid = 1'b0;
         checks++;
         if (n_out !== NW'(e_n[i]) || busy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL range%0d_n: n %0d busy %b err %b want %0d 0 0",
                     i, n_out, busy, err, e_n[i]);
         end
      end
   endtask

   task automatic test_start();
      rx_byte(8'hFE);
      rx_byte(8'h01);
      rx_data  = 8'h03;
      rx_valid = 1'b1;
      #4;
      checks++;
      if ({start, err} !== 2'b10) begin
         errors++;
         $display("FAIL start_pulse: start,err got %b want 10", {start, err});
      end
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      checks++;
      if ({start, busy} !== 2'b00) begin
         errors++;
         $display("FAIL start_end: start,busy got %b want 00", {start, busy});
      end
   endtask

   task automatic test_load_mat();
      logic [7:0]    d;
      logic [CH-1:0] e;
      int            bad = 0;
      set_n(8'h05);
      rx_byte(8'hFE);
      rx_byte(8'h1A);
      rx_byte(8'h04);
      for (int k = 0; k < 25; k++) begin
         d = (k == 7) ? 8'hFE : (k == 8) ? 8'hEF : 8'(k + 16);
         e = CH'(1) << ((k / 5) % CH);
         rx_data  = d;
         rx_valid = 1'b1;
         #4;
         checks++;
         if (mat_push !== e || vec_push !== 1'b0 || wr_data !== d) begin
            errors++;
            bad++;
            $display("FAIL mat%0d: mat %b vec %b data %h want %b 0 %h",
                     k, mat_push, vec_push, wr_data, e, d);
         end
         @(posedge clk);
         #1;
         rx_valid = 1'b0;
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL mat_end: busy got %b want 0", busy);
      end
   endtask

   task automatic test_tx();
      logic [7:0] got  [$];
      logic [7:0] fifo [$];
      logic [7:0] exp  [5] = '{8'hFE, 8'h03, 8'h11, 8'h22, 8'hEF};
      int         pops = 0;
      int         stall_cyc = 0;
      int         stall_bad = 0;
      int         bcnt = 0;
      bit         done = 1'b0;
      bit         loaded = 1'b0;
      logic       s;
      logic       p;
      logic [7:0] d;
      set_n(8'h02);
      tx_ready  = 1'b1;
      res_empty = 1'b1;
      res_data  = '0;
      rx_byte(8'hFE);
      rx_byte(8'h01);
      rx_byte(8'h02);
      for (int cyc = 0; cyc < 300 && !done; cyc++) begin
         #4;
         s = tx_send;
         p = res_pop;
         d = tx_data;
         if (busy && got.size() == 2 && fifo.size() == 0) begin
            stall_cyc++;
            if (s || p) stall_bad++;
         end
         if (!busy && got.size() == 5) done = 1'b1;
         @(posedge clk);
         #1;
         if (p) begin
            pops++;
            if (fifo.size() > 0) void'(fifo.pop_front());
         end
         if (s && tx_ready) begin
            got.push_back(d);
            tx_ready = 1'b0;
            bcnt     = 2;
         end else if (!tx_ready) begin
            if (bcnt == 0) tx_ready = 1'b1;
            else bcnt--;
         end
         if (cyc == 40 && !loaded) begin
            fifo.push_back(8'h11);
            fifo.push_back(8'h22);
            loaded = 1'b1;
         end
         res_empty = (fifo.size() == 0);
         res_data  = res_empty ? '0 : fifo[0];
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL tx_timeout: sent %0d bytes busy %b want 5 bytes idle",
                  got.size(), busy);
      end
      checks++;
      if (got.size() != 5) begin
         errors++;
         $display("FAIL tx_count: got %0d bytes want 5", got.size());
      end
      for (int i = 0; i < 5; i++) begin
         if (i < got.size()) begin
            checks++;
            if (got[i] !== exp[i]) begin
               errors++;
               $display("FAIL tx_byte%0d: got %h want %h", i, got[i], exp[i]);
            end
         end
      end
      checks++;
      if (pops != 2) begin
         errors++;
         $display("FAIL tx_pops: got %0d want 2", pops);
      end
      checks++;
      if (stall_cyc < 20 || stall_bad != 0) begin
         errors++;
         $display("FAIL tx_stall: stall cycles %0d with send/pop %0d want >=20 and 0",
                  stall_cyc, stall_bad);
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] outs;
      rx_byte(8'hFE);
      rx_byte(8'h05);
      rx_byte(8'h04);
      rx_byte(8'h31);
      rx_byte(8'h32);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL mid_busy: got %b want 1", busy);
      end
      reset    = 1'b1;
      rx_valid = 1'b1;
      rx_data  = 8'h55;
      #4;
      checks++;
      if (mat_push !== '0 || vec_push !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_push: mat %b vec %b want 0000 0", mat_push, vec_push);
      end
      @(posedge clk);
      #1;
      reset    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      #4;
      outs = {tx_send, res_pop, vec_push, mat_push, start, err, busy, tx_data};
      checks++;
      if (outs !== 16'h0000 || n_out !== NW'(1)) begin
         errors++;
         $display("FAIL mid_reset: outs %h n %0d want 0000 1", outs, n_out);
      end
      @(posedge clk);
      #1;
      set_n(8'h03);
      checks++;
      if (n_out !== NW'(3) || busy !== 1'b0) begin
         errors++;
         $display("FAIL back_to_back: n %0d busy %b want 3 0", n_out, busy);
      end
   endtask

   initial begin
      test_reset();
      test_set_n();
      test_load_vec();
      test_set_n_range();
      test_start();
      test_load_mat();
      test_tx();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
